// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: shares single-port DM between the MEM stage (cpu)
// and an external loader/debug port (ext). CPU has fixed priority, bounded by
// a starvation counter; ext may lock the port across multi-word bursts.
module dm_port_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    // CPU (MEM stage) side
    input  logic              cpu_req,
    input  logic [3:0]        cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    // External loader/debug side
    input  logic              ext_req,
    input  logic              ext_lock,
    input  logic [3:0]        ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    // Data memory side
    output logic              mem_cs,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned     CntW   = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

    typedef enum logic [0:0] {StArb, StLock} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] starve_q, starve_d;
    logic            cpu_rvalid_q, ext_rvalid_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StArb;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter LOCK with a locked ext grant, leave once ext_lock drops
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StArb:   if (ext_gnt && ext_lock) state_d = StLock;
            StLock:  if (!ext_lock) state_d = StArb;
            default: state_d = StArb;
        endcase
    end

    // Grant decode; nothing is granted while reset is held
    always_comb begin
        cpu_gnt = 1'b0;
        ext_gnt = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StArb: begin
                    if (ext_req && (!cpu_req || starve_q == CntMax)) begin
                        ext_gnt = 1'b1;
                    end else begin
                        cpu_gnt = cpu_req;
                    end
                end
                StLock:  ext_gnt = ext_req;
                default: ;
            endcase
        end
    end

    // Starvation count: consecutive ARB cycles in which ext asked and lost
    always_comb begin
        starve_d = '0;
        if (state_q == StArb && ext_req && !ext_gnt) begin
            starve_d = (starve_q == CntMax) ? CntMax : starve_q + CntW'(1);
        end
    end

    // Starvation counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // Memory port mux: mirrors the granted requester, idle bus is all zero
    always_comb begin
        mem_cs    = cpu_gnt | ext_gnt;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ext_gnt) begin
            mem_we    = ext_we;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
        end
    end

    // Read-return tracking: remember which owner issued a read last cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rvalid_q <= 1'b0;
            ext_rvalid_q <= 1'b0;
        end else begin
            cpu_rvalid_q <= cpu_gnt && (cpu_we == 4'b0000);
            ext_rvalid_q <= ext_gnt && (ext_we == 4'b0000);
        end
    end

    // Read data routing; returns are suppressed while reset is held
    always_comb begin
        cpu_rvalid = cpu_rvalid_q && !rst;
        ext_rvalid = ext_rvalid_q && !rst;
        cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
        ext_rdata  = ext_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: DM behavioural memory, a transaction-level
// model checked every cycle, and directed scenarios with literal expectations.
module tb_dm_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_gnt, cpu_rvalid;
    logic [3:0]    cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          ext_req, ext_lock, ext_gnt, ext_rvalid;
    logic [3:0]    ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata, ext_rdata;
    logic          mem_cs;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    dm_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_lock(ext_lock), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
        .ext_rdata(ext_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- DM environment (responds to what the DUT drives) ----------
    logic [31:0] env_mem [int];
    logic [31:0] mdl_mem [int];
    bit          p_rd, p_wr;
    int          p_idx;
    logic [3:0]  p_we;
    logic [31:0] p_wd;

    always @(negedge clk) begin
        p_rd  = mem_cs && (mem_we == 4'b0000);
        p_wr  = mem_cs && (mem_we != 4'b0000);
        p_idx = int'(mem_addr >> 2);
        p_we  = mem_we;
        p_wd  = mem_wdata;
    end

    always @(posedge clk) begin
        logic [31:0] w;
        cyc++;
        // Non-read cycles return noise so any ungated rdata shows up
        if (p_rd) mem_rdata <= env_mem.exists(p_idx) ? env_mem[p_idx] : 32'h0;
        else      mem_rdata <= 32'hBAD0_0000 ^ cyc;
        if (p_wr) begin
            w = env_mem.exists(p_idx) ? env_mem[p_idx] : 32'h0;
            for (int b = 0; b < 4; b++) if (p_we[b]) w[8*b +: 8] = p_wd[8*b +: 8];
            env_mem[p_idx] = w;
        end
    end

    // ---------------- Transaction-level model + per-cycle compare ----------------
    bit          m_locked = 0;
    int          m_denied = 0;
    bit          m_rv_cpu = 0, m_rv_ext = 0;
    logic [31:0] m_word = 0;

    always @(negedge clk) begin
        bit          gc, ge;
        logic [3:0]  ew;
        logic [15:0] ea;
        logic [31:0] ed, w;
        int          idx;
        // Who owns the port this cycle
        if (rst) begin
            gc = 0; ge = 0;
        end else if (m_locked) begin
            gc = 0; ge = ext_req;
        end else begin
            ge = ext_req && (!cpu_req || m_denied >= SM);
            gc = cpu_req && !ge;
        end
        ew = gc ? cpu_we    : ge ? ext_we    : 4'h0;
        ea = gc ? cpu_addr  : ge ? ext_addr  : 16'h0;
        ed = gc ? cpu_wdata : ge ? ext_wdata : 32'h0;
        if (chk_en) begin
            chk("cpu_gnt",    cpu_gnt,    gc);
            chk("ext_gnt",    ext_gnt,    ge);
            chk("mem_cs",     mem_cs,     gc || ge);
            chk("mem_we",     mem_we,     ew);
            chk("mem_addr",   mem_addr,   ea);
            chk("mem_wdata",  mem_wdata,  ed);
            chk("cpu_rvalid", cpu_rvalid, m_rv_cpu && !rst);
            chk("ext_rvalid", ext_rvalid, m_rv_ext && !rst);
            chk("cpu_rdata",  cpu_rdata,  (m_rv_cpu && !rst) ? m_word : 32'h0);
            chk("ext_rdata",  ext_rdata,  (m_rv_ext && !rst) ? m_word : 32'h0);
        end
        // Advance to the next cycle (inputs are stable until after the edge)
        if (rst) begin
            m_locked = 0; m_denied = 0; m_rv_cpu = 0; m_rv_ext = 0;
        end else begin
            idx = int'(ea >> 2);
            m_rv_cpu = gc && (cpu_we == 4'h0);
            m_rv_ext = ge && (ext_we == 4'h0);
            if (gc || ge) begin
                w = mdl_mem.exists(idx) ? mdl_mem[idx] : 32'h0;
                if (ew == 4'h0) m_word = w;
                else begin
                    for (int b = 0; b < 4; b++) if (ew[b]) w[8*b +: 8] = ed[8*b +: 8];
                    mdl_mem[idx] = w;
                end
            end
            m_denied = (!m_locked && ext_req && !ge) ? m_denied + 1 : 0;
            m_locked = m_locked ? ext_lock : (ge && ext_lock);
        end
    end

    // ---------------- Directed stimulus with literal expectations ----------------
    initial begin
        int w;
        env_mem[16'h9000 >> 2] = 32'hDEADBEEF; mdl_mem[16'h9000 >> 2] = 32'hDEADBEEF;
        env_mem[16'hfffc >> 2] = 32'h12345678; mdl_mem[16'hfffc >> 2] = 32'h12345678;
        for (int k = 0; k < 4; k++) begin
            env_mem[(16'h9078 >> 2) + k] = 32'hA5A5A5A5;
            mdl_mem[(16'h9078 >> 2) + k] = 32'hA5A5A5A5;
        end
        rst = 1; ext_lock = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h9000; cpu_wdata = 0;
        ext_req = 1; ext_we = 0; ext_addr = 16'hfffc; ext_wdata = 0;
        chk_en = 1;

        // 1: reset with both requesting
        repeat (2) begin
            @(negedge clk);
            chk("t1_rst_cpu_gnt", cpu_gnt, 0);
            chk("t1_rst_ext_gnt", ext_gnt, 0);
            chk("t1_rst_cs", mem_cs, 0);
            chk("t1_rst_rvalid", {cpu_rvalid, ext_rvalid}, 0);
        end
        tick(); rst = 0;
        @(negedge clk);
        chk("t1_cpu_first", cpu_gnt, 1);
        chk("t1_ext_first", ext_gnt, 0);
        tick(); cpu_req = 0; ext_req = 0;
        tick(); tick();

        // 2: single CPU read
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h9000;
        @(negedge clk); chk("t2_gnt", cpu_gnt, 1);
        tick(); cpu_req = 0;
        @(negedge clk);
        chk("t2_rvalid", cpu_rvalid, 1);
        chk("t2_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("t2_ext_rvalid", ext_rvalid, 0);
        tick();

        // 3: starvation - ext wins on cycles 5 and 10 (counter clears after a win)
        cpu_req = 1; ext_req = 1; ext_lock = 0; ext_we = 0; ext_addr = 16'hfffc;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_cpu_gnt", cpu_gnt, !(i == 4 || i == 9));
            chk("t3_ext_gnt", ext_gnt, (i == 4 || i == 9));
            tick();
        end
        cpu_req = 0; ext_req = 0;
        tick(); tick();

        // 4: locked ext write burst against a persistent CPU request
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h9000;
        w = 0;
        ext_req = 1; ext_we = 4'hF; ext_wdata = 0; ext_addr = 16'h9078; ext_lock = 1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            chk("t4_cpu_gnt", cpu_gnt, (c < 4 || c == 8));
            chk("t4_ext_gnt", ext_gnt, (c >= 4 && c < 8));
            tick();
            if (c >= 4 && c < 8) begin
                w++;
                ext_addr = 16'(16'h9078 + 4 * w);
                ext_lock = (w < 3);
                if (w == 4) ext_req = 0;
            end
        end
        cpu_req = 0; ext_we = 0;
        tick();
        for (int k = 0; k < 4; k++) begin
            cpu_req = 1; cpu_addr = 16'(16'h9078 + 4 * k);
            @(negedge clk); chk("t4_rb_gnt", cpu_gnt, 1);
            tick(); cpu_req = 0;
            @(negedge clk);
            chk("t4_rb_rvalid", cpu_rvalid, 1);
            chk("t4_rb_data", cpu_rdata, 32'h0);
            tick();
        end

        // 5: alternating owners, back-to-back reads
        cpu_req = 1; cpu_addr = 16'h9000;
        @(negedge clk); chk("t5_cpu_gnt", cpu_gnt, 1);
        tick(); cpu_req = 0; ext_req = 1; ext_we = 0; ext_addr = 16'hfffc; ext_lock = 0;
        @(negedge clk);
        chk("t5_ext_gnt", ext_gnt, 1);
        chk("t5_cpu_rvalid", cpu_rvalid, 1);
        chk("t5_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("t5_ext_rvalid_early", ext_rvalid, 0);
        tick(); ext_req = 0;
        @(negedge clk);
        chk("t5_ext_rvalid", ext_rvalid, 1);
        chk("t5_ext_rdata", ext_rdata, 32'h12345678);
        chk("t5_cpu_rvalid_late", cpu_rvalid, 0);
        tick(); tick();

        // 6: reset while locked with an ext read outstanding
        ext_req = 1; ext_lock = 1; ext_we = 0; ext_addr = 16'hfffc;
        @(negedge clk); chk("t6_ext_lock_gnt", ext_gnt, 1);
        tick(); rst = 1; cpu_req = 1; cpu_addr = 16'h9000;
        @(negedge clk);
        chk("t6_rst_ext_rvalid", ext_rvalid, 0);
        chk("t6_rst_ext_rdata", ext_rdata, 0);
        chk("t6_rst_ext_gnt", ext_gnt, 0);
        tick(); rst = 0;
        @(negedge clk);
        chk("t6_cpu_after_rst", cpu_gnt, 1);
        chk("t6_ext_after_rst", ext_gnt, 0);
        chk("t6_ext_rvalid_after", ext_rvalid, 0);
        tick(); cpu_req = 0; ext_req = 0; ext_lock = 0;
        tick(); tick();

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

endmodule
